serve_countdown: RTL and testbench

- Consumer end of the slow-tick interface: takes the one-cycle `tick_in` pulse from the game's clock divider (one pulse per second) and runs a 2-digit BCD countdown.
- Used before each serve and after each point. The display shows the seconds remaining (`remaining`).
- `done` gates ball release.
- Runs entirely on the fast system clock; `tick_in` is a qualifier, never a clock.

---
 rtl/pong_timer_pkg.sv | 35 +++
 rtl/bcd_dec2.sv | 29 ++
 rtl/serve_countdown.sv | 158 +++++++++++++++
 tb/tb_serve_countdown.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_timer_pkg.sv
// pong_timer_pkg
//   Shared types and helpers for the serve countdown timer:
//   - state_t   : countdown FSM state encoding
//   - BCD_W     : width of a 2-digit BCD value
//   - bin2bcd   : binary 0..99 to 2-digit BCD (elaboration-time use)
//   - bcd2bin   : 2-digit BCD to binary, used for threshold compares
//   - bcd_valid : both digits in 0..9
package pong_timer_pkg;

  localparam int BCD_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HOLD   = 2'd2,
    FINISH = 2'd3
  } state_t;

  function automatic logic [BCD_W-1:0] bin2bcd(input int unsigned v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'((v / 10) % 10);
    units = 4'(v % 10);
    return {tens, units};
  endfunction

  function automatic int unsigned bcd2bin(input logic [BCD_W-1:0] b);
    return (int'(b[7:4]) * 10) + int'(b[3:0]);
  endfunction

  function automatic logic bcd_valid(input logic [BCD_W-1:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_dec2.sv
// bcd_dec2
//   Combinational 2-digit BCD decrement. Units 0 wraps to 9 and borrows
//   from the tens digit; 00 wraps to 99 (the FSM never decrements 00).
// Ports:
//   value : current BCD value
//   dec   : value minus one, in BCD
module bcd_dec2
  import pong_timer_pkg::*;
(
  input  logic [BCD_W-1:0] value,
  output logic [BCD_W-1:0] dec
);

  logic [3:0] tens;
  logic [3:0] units;

  always_comb begin
    tens  = value[7:4];
    units = value[3:0];
    if (units == 4'd0) begin
      units = 4'd9;
      tens  = (tens == 4'd0) ? 4'd9 : tens - 4'd1;
    end else begin
      units = units - 4'd1;
    end
    dec = {tens, units};
  end

endmodule

// File: rtl/serve_countdown.sv
// serve_countdown
//   2-digit BCD countdown run before each serve. Counts down once per
//   rising edge of the slow tick qualifier; done pulses when 00 is reached.
//   Optional warning blink enabled by defining SERVE_WARN_BLINK_EN.
// Ports:
//   clock     : system clock, rising edge
//   reset     : synchronous, active-high
//   tick_in   : 1 Hz qualifier from the divider (level pulse)
//   start     : begin countdown, honoured only in IDLE
//   pause     : level, freezes the countdown
//   abort     : cancel the countdown without done
//   load_bcd  : start value, [7:4] tens, [3:0] units
//   remaining : current BCD value
//   busy      : high in RUN or HOLD
//   done      : one-cycle pulse on reaching 00
//   warn      : blink output (0 unless SERVE_WARN_BLINK_EN)
//
// state  | meaning
// -------+-------------------------------------------------
// IDLE   | waiting for start; remaining holds last value
// RUN    | counting down on each tick edge
// HOLD   | paused; ticks are discarded
// FINISH | reached 00; done high for this one cycle
module serve_countdown
  import pong_timer_pkg::*;
#(
  parameter int START_SECONDS = 3,
  parameter int WARN_LEVEL    = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic [BCD_W-1:0] load_bcd,
  output logic [BCD_W-1:0] remaining,
  output logic             busy,
  output logic             done,
  output logic             warn
);

  if (START_SECONDS < 1 || START_SECONDS > 99) begin : g_bad_start
    $error("serve_countdown: START_SECONDS must be 1..99");
  end
  if (WARN_LEVEL < 1 || WARN_LEVEL > 99) begin : g_bad_warn
    $error("serve_countdown: WARN_LEVEL must be 1..99");
  end

  localparam logic [BCD_W-1:0] START_BCD = bin2bcd(START_SECONDS);

  state_t           state;
  logic             tick_q;
  logic             tick_ev;
  logic [BCD_W-1:0] load_val;
  logic [BCD_W-1:0] dec_val;

  // tick_q resets low, but the FSM is in IDLE after reset, so a tick held
  // across reset release can never decrement anything.
  assign tick_ev  = tick_in & ~tick_q;
  assign load_val = (bcd_valid(load_bcd) && (load_bcd != '0)) ? load_bcd : START_BCD;

  bcd_dec2 u_dec (
    .value (remaining),
    .dec   (dec_val)
  );

`ifdef SERVE_WARN_BLINK_EN
  logic warn_r;
  assign warn = warn_r;
`else
  assign warn = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tick_q    <= 1'b0;
`ifdef SERVE_WARN_BLINK_EN
      warn_r    <= 1'b0;
`endif
    end else begin
      tick_q <= tick_in;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            remaining <= load_val;
            busy      <= 1'b1;
`ifdef SERVE_WARN_BLINK_EN
            warn_r    <= 1'b0;
`endif
          end
        end

        RUN: begin
          if (abort) begin
            state     <= IDLE;
            remaining <= '0;
            busy      <= 1'b0;
`ifdef SERVE_WARN_BLINK_EN
            warn_r    <= 1'b0;
`endif
          end else if (pause) begin
            // a tick in the same cycle as pause is deliberately dropped
            state <= HOLD;
          end else if (tick_ev) begin
            if (remaining == 8'h01) begin
              state     <= FINISH;
              remaining <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
`ifdef SERVE_WARN_BLINK_EN
              warn_r    <= 1'b0;
`endif
            end else begin
              remaining <= dec_val;
`ifdef SERVE_WARN_BLINK_EN
              // threshold judged on the value this tick lands on
              if (bcd2bin(dec_val) <= WARN_LEVEL) warn_r <= ~warn_r;
              else                                warn_r <= 1'b0;
`endif
            end
          end
        end

        HOLD: begin
          if (abort) begin
            state     <= IDLE;
            remaining <= '0;
            busy      <= 1'b0;
`ifdef SERVE_WARN_BLINK_EN
            warn_r    <= 1'b0;
`endif
          end else if (!pause) begin
            state <= RUN;
          end
        end

        FINISH: begin
          // start is ignored here; a restart needs start in a later cycle
          state <= IDLE;
        end

        default: begin
          state     <= IDLE;
          remaining <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serve_countdown.sv
module tb_serve_countdown;

  logic       clock;
  logic       reset;
  logic       tick_in;
  logic       start;
  logic       pause;
  logic       abort;
  logic [7:0] load_bcd;
  logic [7:0] remaining;
  logic       busy;
  logic       done;
  logic       warn;

  int tests;
  int fails;

  serve_countdown #(.START_SECONDS(3), .WARN_LEVEL(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .tick_in   (tick_in),
    .start     (start),
    .pause     (pause),
    .abort     (abort),
    .load_bcd  (load_bcd),
    .remaining (remaining),
    .busy      (busy),
    .done      (done),
    .warn      (warn)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // advance n rising edges and settle 1 time unit past the last one
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [7:0] v);
    load_bcd = v;
    start    = 1'b1;
    step(1);
    start    = 1'b0;
  endtask

  task automatic do_tick();
    tick_in = 1'b1;
    step(1);
    tick_in = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step(1);
    abort = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick_in = 1'b1;
    step(2);
    tests++; if (remaining !== 8'h00) begin fails++; $display("FAIL reset_remaining got %h want 00", remaining); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (warn !== 1'b0) begin fails++; $display("FAIL reset_warn got %b want 0", warn); end
    reset = 1'b0;   // tick still high across release
    step(2);
    tick_in = 1'b0;
    step(1);
    tests++; if (remaining !== 8'h00 || busy !== 1'b0) begin fails++; $display("FAIL reset_tick_release got rem=%h busy=%b want 00/0", remaining, busy); end
  endtask

  task automatic test_basic();
    do_start(8'h03);
    tests++; if (remaining !== 8'h03 || busy !== 1'b1) begin fails++; $display("FAIL basic_load got rem=%h busy=%b want 03/1", remaining, busy); end
    step(19); do_tick();
    tests++; if (remaining !== 8'h02) begin fails++; $display("FAIL basic_t1 got %h want 02", remaining); end
    step(19); do_tick();
    tests++; if (remaining !== 8'h01 || done !== 1'b0) begin fails++; $display("FAIL basic_t2 got rem=%h done=%b want 01/0", remaining, done); end
    step(19); do_tick();
    tests++; if (remaining !== 8'h00 || done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL basic_t3 got rem=%h done=%b busy=%b want 00/1/0", remaining, done, busy); end
    step(1);
    tests++; if (done !== 1'b0 || remaining !== 8'h00) begin fails++; $display("FAIL basic_done_pulse got done=%b rem=%h want 0/00", done, remaining); end
    do_start(8'h42);   // IDLE reached: start honoured
    tests++; if (remaining !== 8'h42 || busy !== 1'b1) begin fails++; $display("FAIL basic_idle_after got rem=%h busy=%b want 42/1", remaining, busy); end
    do_abort();
  endtask

  task automatic test_borrow_wide();
    do_start(8'h10);
    tick_in = 1'b1;
    step(1);
    tests++; if (remaining !== 8'h09) begin fails++; $display("FAIL borrow got %h want 09", remaining); end
    step(4);
    tick_in = 1'b0;
    step(2);
    tests++; if (remaining !== 8'h09) begin fails++; $display("FAIL wide_tick got %h want 09", remaining); end
    do_abort();
    tests++; if (remaining !== 8'h00 || busy !== 1'b0) begin fails++; $display("FAIL abort_run got rem=%h busy=%b want 00/0", remaining, busy); end
    do_start(8'h1A);
    tests++; if (remaining !== 8'h03) begin fails++; $display("FAIL invalid_load got %h want 03", remaining); end
    do_abort();
    do_start(8'h00);
    tests++; if (remaining !== 8'h03) begin fails++; $display("FAIL zero_load got %h want 03", remaining); end
    do_abort();
    do_start(8'h99);
    step(2); do_tick();
    tests++; if (remaining !== 8'h98) begin fails++; $display("FAIL load_99 got %h want 98", remaining); end
    do_abort();
    do_start(8'h20);
    step(2); do_tick();
    tests++; if (remaining !== 8'h19) begin fails++; $display("FAIL borrow_20 got %h want 19", remaining); end
    do_abort();
  endtask

  task automatic test_pause();
    do_start(8'h05);
    step(2);
    pause = 1'b1; tick_in = 1'b1;
    step(1);
    tick_in = 1'b0;
    tests++; if (remaining !== 8'h05 || busy !== 1'b1) begin fails++; $display("FAIL pause_tick_lost got rem=%h busy=%b want 05/1", remaining, busy); end
    step(5); do_tick();
    step(5); do_tick();
    tests++; if (remaining !== 8'h05) begin fails++; $display("FAIL pause_hold got %h want 05", remaining); end
    pause = 1'b0;
    step(3);
    tests++; if (remaining !== 8'h05 || busy !== 1'b1) begin fails++; $display("FAIL pause_release got rem=%h busy=%b want 05/1", remaining, busy); end
    do_tick();
    tests++; if (remaining !== 8'h04) begin fails++; $display("FAIL pause_resume got %h want 04", remaining); end
    pause = 1'b1; step(2);
    do_abort();
    pause = 1'b0;
    tests++; if (remaining !== 8'h00 || busy !== 1'b0) begin fails++; $display("FAIL abort_hold got rem=%h busy=%b want 00/0", remaining, busy); end
  endtask

  task automatic test_abort_final();
    do_start(8'h01);
    step(2);
    tick_in = 1'b1; abort = 1'b1;
    step(1);
    tick_in = 1'b0; abort = 1'b0;
    tests++; if (remaining !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL abort_final got rem=%h busy=%b done=%b want 00/0/0", remaining, busy, done); end
    step(1);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL abort_final_nodone got %b want 0", done); end
    do_tick();
    tests++; if (remaining !== 8'h00 || busy !== 1'b0) begin fails++; $display("FAIL abort_idle_tick got rem=%h busy=%b want 00/0", remaining, busy); end
  endtask

  task automatic test_reset_mid_run();
    do_start(8'h07);
    step(2); do_tick();
    tests++; if (remaining !== 8'h06) begin fails++; $display("FAIL midrun_dec got %h want 06", remaining); end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    tests++; if (remaining !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || warn !== 1'b0) begin fails++; $display("FAIL midrun_reset got rem=%h busy=%b done=%b warn=%b want 00/0/0/0", remaining, busy, done, warn); end
    step(2); do_tick();
    tests++; if (remaining !== 8'h00 || busy !== 1'b0) begin fails++; $display("FAIL midrun_idle got rem=%h busy=%b want 00/0", remaining, busy); end
  endtask

  task automatic test_start_in_finish();
    do_start(8'h01);
    step(2); do_tick();
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL finish_done got %b want 1", done); end
    do_start(8'h05);   // start asserted during the FINISH cycle
    tests++; if (busy !== 1'b0 || remaining !== 8'h00 || done !== 1'b0) begin fails++; $display("FAIL finish_start got busy=%b rem=%h done=%b want 0/00/0", busy, remaining, done); end
    step(2);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL finish_start_late got busy=%b want 0", busy); end
    do_start(8'h05);
    tests++; if (busy !== 1'b1 || remaining !== 8'h05) begin fails++; $display("FAIL restart got busy=%b rem=%h want 1/05", busy, remaining); end
    do_abort();
  endtask

  task automatic test_warn();
    logic [7:0] exp_rem [6];
    logic       exp_warn [6];
    exp_rem = '{8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
`ifdef SERVE_WARN_BLINK_EN
    exp_warn = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_warn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    do_start(8'h05);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        step(3); do_tick();
      end
      tests++;
      if (remaining !== exp_rem[i] || warn !== exp_warn[i]) begin
        fails++;
        $display("FAIL warn_step%0d got rem=%h warn=%b want %h/%b", i, remaining, warn, exp_rem[i], exp_warn[i]);
      end
    end
    step(2);
    tests++; if (warn !== 1'b0) begin fails++; $display("FAIL warn_after_done got %b want 0", warn); end
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b1; tick_in = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0; load_bcd = 8'h00;
    step(1);
    test_reset();
    test_basic();
    test_borrow_wide();
    test_pause();
    test_abort_final();
    test_reset_mid_run();
    test_start_in_finish();
    test_warn();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
